// File: rtl/ofdm_pkg.sv
// Shared OFDM defaults, controller state encoding and complex sample layout.
package ofdm_pkg;

  localparam int         N_DEF        = 32;
  localparam int         CP_DEF       = 16;
  localparam int         DW_DEF       = 32;
  localparam logic [7:0] CFG_WORD_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIG  = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } cplx_t;

endpackage

// File: rtl/ifft_symbol_controller_if.sv
// AXI-stream channel bundle used for every stream port of the symbol controller.
interface ifft_symbol_controller_if
  import ofdm_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/symbol_buffer.sv
// Simple dual-port symbol RAM: one write port, one registered read port.
module symbol_buffer
  import ofdm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 aclk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [DW-1:0]        wdata,
  input  logic                 re,
  input  logic [$clog2(N)-1:0] raddr,
  output logic [DW-1:0]        rdata
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge aclk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ifft_symbol_controller.sv
// Sequences one OFDM symbol through an external AXI-stream IFFT core and
// emits the cyclic-prefixed result from a local buffer.
//
// state   | meaning
// IDLE    | waiting for a mapper sample (not consumed)
// CONFIG  | offering the inverse-transform config word
// LOAD    | passing N mapper samples straight into the core
// CAPTURE | writing core output beats into the buffer
// EMIT    | streaming CP tail then full symbol through the skid stage
module ifft_symbol_controller
  import ofdm_pkg::*;
#(
  parameter int         N        = N_DEF,
  parameter int         CP       = CP_DEF,
  parameter int         DW       = DW_DEF,
  parameter logic [7:0] CFG_WORD = CFG_WORD_DEF
) (
  input  logic aclk,
  input  logic aresetn,
  ifft_symbol_controller_if.slave  s,
  ifft_symbol_controller_if.master cfg,
  ifft_symbol_controller_if.master fft_s,
  ifft_symbol_controller_if.slave  fft_m,
  ifft_symbol_controller_if.master m,
  output logic busy,
  output logic done,
  output logic err_tlast
);

  localparam int              AW       = $clog2(N);
  localparam int              LW       = $clog2(N + CP + 1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0]   RD_START = AW'(N - CP);
  localparam logic [LW-1:0]   EMIT_LEN = LW'(N + CP);

  state_t        state_q, state_d;
  logic [AW-1:0] load_cnt, cap_cnt, rd_addr;
  logic [LW-1:0] rd_left;
  logic          load_hs, cap_hs, cap_end, cap_err, out_hs;
  logic          rd_issue, rd_vld, rd_last_q;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] sk_data [2];
  logic          sk_last [2];
  logic          sk_wp, sk_rp;
  logic [1:0]    sk_cnt;
  logic          unused_s_tlast;

  assign unused_s_tlast = s.tlast;

  assign load_hs = (state_q == ST_LOAD) && s.tvalid && fft_s.tready;
  assign cap_hs  = (state_q == ST_CAPTURE) && fft_m.tvalid;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    s.tready     = 1'b0;
    cfg.tvalid   = 1'b0;
    cfg.tdata    = '0;
    cfg.tlast    = 1'b0;
    fft_s.tdata  = '0;
    fft_s.tvalid = 1'b0;
    fft_s.tlast  = 1'b0;
    fft_m.tready = 1'b0;
    cap_end      = 1'b0;
    cap_err      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (s.tvalid) state_d = ST_CONFIG;
      ST_CONFIG: begin
        cfg.tvalid = 1'b1;
        cfg.tdata  = CFG_WORD;
        if (cfg.tready) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fft_s.tdata  = s.tdata;
        fft_s.tvalid = s.tvalid;
        fft_s.tlast  = (load_cnt == LAST_IDX);
        s.tready     = fft_s.tready;
        if (load_hs && load_cnt == LAST_IDX) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        fft_m.tready = 1'b1;
        if (fft_m.tvalid) begin
          if (cap_cnt == LAST_IDX) begin
            cap_end = 1'b1;
            cap_err = !fft_m.tlast;
          end else if (fft_m.tlast) begin
            cap_end = 1'b1;
            cap_err = 1'b1;
          end
        end
        if (cap_end) state_d = ST_EMIT;
      end
      ST_EMIT: if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // A read may issue only if its data will find a free skid slot next cycle.
  assign rd_issue = (state_q == ST_EMIT) && (rd_left != '0) &&
                    ((int'(sk_cnt) + int'(rd_vld) - int'(out_hs)) < 2);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      load_cnt  <= '0;
      cap_cnt   <= '0;
      rd_addr   <= '0;
      rd_left   <= '0;
      rd_vld    <= 1'b0;
      rd_last_q <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      if (load_hs) load_cnt <= load_cnt + AW'(1);
      if (cap_hs)  cap_cnt  <= cap_end ? '0 : cap_cnt + AW'(1);
      if (cap_err) err_tlast <= 1'b1;
      if (state_q != ST_EMIT) begin
        rd_addr <= RD_START;
        rd_left <= EMIT_LEN;
      end else if (rd_issue) begin
        rd_addr <= rd_addr + AW'(1);
        rd_left <= rd_left - LW'(1);
      end
      rd_vld    <= rd_issue;
      rd_last_q <= rd_issue && (rd_left == LW'(1));
    end
  end

  symbol_buffer #(.N(N), .DW(DW)) u_buf (
    .aclk  (aclk),
    .we    (cap_hs),
    .waddr (cap_cnt),
    .wdata (fft_m.tdata),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign m.tvalid = (sk_cnt != 2'd0);
  assign m.tdata  = sk_data[sk_rp];
  assign m.tlast  = sk_last[sk_rp] && m.tvalid;
  assign out_hs   = m.tvalid && m.tready;
  assign done     = out_hs && m.tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        sk_data[i] <= '0;
        sk_last[i] <= 1'b0;
      end
      sk_wp  <= 1'b0;
      sk_rp  <= 1'b0;
      sk_cnt <= 2'd0;
    end else begin
      if (rd_vld) begin
        sk_data[sk_wp] <= rd_data;
        sk_last[sk_wp] <= rd_last_q;
        sk_wp          <= ~sk_wp;
      end
      if (out_hs) sk_rp <= ~sk_rp;
      case ({rd_vld, out_hs})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_symbol_controller.sv
// Scoreboard bench for ifft_symbol_controller with an echo IFFT core model.
module tb_ifft_symbol_controller;
  import ofdm_pkg::*;

  localparam int N      = 32;
  localparam int CP     = 16;
  localparam int CORE_L = 5;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic aclk, aresetn, busy, done, err_tlast;

  ifft_symbol_controller_if #(.DW(32)) s_if();
  ifft_symbol_controller_if #(.DW(8))  cfg_if();
  ifft_symbol_controller_if #(.DW(32)) fft_s_if();
  ifft_symbol_controller_if #(.DW(32)) fft_m_if();
  ifft_symbol_controller_if #(.DW(32)) m_if();

  ifft_symbol_controller #(.N(N), .CP(CP), .DW(32), .CFG_WORD(8'h00)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s         (s_if),
    .cfg       (cfg_if),
    .fft_s     (fft_s_if),
    .fft_m     (fft_m_if),
    .m         (m_if),
    .busy      (busy),
    .done      (done),
    .err_tlast (err_tlast)
  );

  int   n_vec = 0;
  int   n_miss = 0;
  int   done_cnt = 0;
  int   beat_cnt = 0;
  int   fs_early = 0;
  int   cfg_stall = 0;
  int   core_tlast_at = N - 1;
  bit   rand_in = 0;
  bit   rand_out = 0;
  exp_t exp_q [$];
  logic [31:0] mdl_buf [N];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running, required finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] samp(input int base, input int k);
    cplx_t c;
    c.re = 16'(base + k);
    c.im = 16'(40000 - 3 * (base + k));
    return c;
  endfunction

  function automatic logic [127:0] outs_vec();
    return {46'd0, s_if.tready, cfg_if.tvalid, cfg_if.tdata, fft_s_if.tvalid, fft_s_if.tlast,
            fft_s_if.tdata, fft_m_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata,
            busy, done, err_tlast};
  endfunction

  // Echo core writes the first last_at+1 slots; later slots keep the previous symbol.
  task automatic push_symbol(input int base, input int last_at);
    exp_t e;
    for (int j = 0; j <= last_at; j++) mdl_buf[j] = samp(base, j);
    for (int b = 0; b < N + CP; b++) begin
      e.data = mdl_buf[(N - CP + b) % N];
      e.last = (b == N + CP - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_symbol(input int base, input int exp_done, input bit hold);
    int k;
    int g;
    k = 0;
    g = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = samp(base, 0);
    while (k < N && g < 4000) begin
      @(negedge aclk);
      g++;
      if (s_if.tvalid && s_if.tready) begin
        if (k == 0) check("accept_after_done", done_cnt, exp_done);
        k++;
      end
      @(posedge aclk);
      #1;
      if (k < N) s_if.tdata = samp(base, k);
    end
    check("load_complete", k, N);
    if (!hold) s_if.tvalid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 3000) begin
      @(posedge aclk);
      g++;
    end
    @(posedge aclk);
    #1;
    check("done_count", done_cnt, target);
  endtask

  initial begin : m_ready_drv
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.tready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        pst;
    logic [31:0] pd;
    logic        pl;
    pst = 1'b0;
    pd  = '0;
    pl  = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pst      = 1'b0;
        beat_cnt = 0;
      end else begin
        if (done) done_cnt++;
        if (pst) check("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, pl, pd});
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_beat: actual %0h required no beat", m_if.tdata);
          end else begin
            e = exp_q.pop_front();
            check("m_tdata", m_if.tdata, e.data);
            check("m_tlast", m_if.tlast, e.last);
            check("done_pulse", done, e.last);
          end
          beat_cnt = m_if.tlast ? 0 : beat_cnt + 1;
        end
        pst = m_if.tvalid && !m_if.tready;
        pd  = m_if.tdata;
        pl  = m_if.tlast;
      end
    end
  end

  initial begin : cfg_side
    int cfg_sym;
    bit cfg_ok;
    cfg_sym = 0;
    cfg_ok  = 1'b0;
    cfg_if.tready = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        cfg_sym = 0;
        cfg_ok  = 1'b0;
      end else begin
        if (cfg_if.tvalid && cfg_if.tready) begin
          check("cfg_tdata", cfg_if.tdata, 8'h00);
          cfg_ok = 1'b1;
          cfg_sym++;
        end
        if (fft_s_if.tvalid && !cfg_ok) fs_early++;
        if (done) begin
          check("cfg_per_symbol", cfg_sym, 1);
          cfg_sym = 0;
          cfg_ok  = 1'b0;
        end
      end
      @(posedge aclk);
      #1;
      if (cfg_if.tvalid && cfg_stall > 0) begin
        cfg_if.tready = 1'b0;
        cfg_stall--;
      end else begin
        cfg_if.tready = cfg_if.tvalid;
      end
    end
  end

  initial begin : core
    int          in_idx;
    int          g;
    bit          hs;
    logic [31:0] cbuf [N];
    in_idx = 0;
    fft_s_if.tready = 1'b1;
    fft_m_if.tvalid = 1'b0;
    fft_m_if.tdata  = '0;
    fft_m_if.tlast  = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        in_idx = 0;
      end else if (fft_s_if.tvalid && fft_s_if.tready) begin
        check("fft_s_tlast", fft_s_if.tlast, in_idx == N - 1);
        cbuf[in_idx] = fft_s_if.tdata;
        in_idx++;
      end
      @(posedge aclk);
      #1;
      fft_s_if.tready = rand_in ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_idx == N) begin
        in_idx = 0;
        repeat (CORE_L) @(posedge aclk);
        #1;
        for (int j = 0; j <= core_tlast_at; j++) begin
          fft_m_if.tvalid = 1'b1;
          fft_m_if.tdata  = cbuf[j];
          fft_m_if.tlast  = (j == core_tlast_at);
          hs = 1'b0;
          g  = 0;
          while (!hs && g < 1000) begin
            @(negedge aclk);
            g++;
            hs = fft_m_if.tready;
            @(posedge aclk);
            #1;
          end
          check("core_out_accepted", hs, 1'b1);
        end
        fft_m_if.tvalid = 1'b0;
        fft_m_if.tlast  = 1'b0;
      end
    end
  end

  initial begin : main
    int g;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    aresetn     = 1'b1;
    #1 aresetn  = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_outputs", outs_vec(), '0);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    push_symbol(16'h0100, N - 1);
    send_symbol(16'h0100, 0, 1'b0);
    wait_done(1);
    check("err_tlast_clean", err_tlast, 1'b0);

    cfg_stall = 10;
    push_symbol(16'h0200, N - 1);
    send_symbol(16'h0200, 1, 1'b0);
    wait_done(2);

    rand_in  = 1'b1;
    rand_out = 1'b1;
    push_symbol(16'h0300, N - 1);
    send_symbol(16'h0300, 2, 1'b0);
    wait_done(3);
    rand_in  = 1'b0;
    rand_out = 1'b0;

    core_tlast_at = 19;
    push_symbol(16'h0400, 19);
    send_symbol(16'h0400, 3, 1'b0);
    wait_done(4);
    check("err_tlast_early", err_tlast, 1'b1);
    core_tlast_at = N - 1;

    push_symbol(16'h0500, N - 1);
    send_symbol(16'h0500, 4, 1'b0);
    wait_done(5);
    check("err_tlast_sticky", err_tlast, 1'b1);

    push_symbol(16'h0600, N - 1);
    send_symbol(16'h0600, 5, 1'b0);
    g = 0;
    while (beat_cnt < 29 && g < 3000) begin
      @(negedge aclk);
      g++;
    end
    check("reach_beat_30", beat_cnt >= 29, 1'b1);
    #1 aresetn = 1'b0;
    #1 check("reset_mid_emit", outs_vec(), '0);
    exp_q.delete();
    repeat (3) @(negedge aclk);
    check("reset_hold", outs_vec(), '0);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    push_symbol(16'h0700, N - 1);
    send_symbol(16'h0700, 5, 1'b0);
    wait_done(6);
    check("err_tlast_after_reset", err_tlast, 1'b0);

    push_symbol(16'h0800, N - 1);
    send_symbol(16'h0800, 6, 1'b1);
    push_symbol(16'h0900, N - 1);
    send_symbol(16'h0900, 7, 1'b0);
    wait_done(8);

    check("fft_s_before_cfg", fs_early, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
